fp_accumulator: RTL and testbench
=================================

// Module: fp_accumulator
// PURPOSE
//  Streaming floating-point accumulator that sits around the combinational fp_adder.
//  - Accepts a valid/ready stream of operands, one packet per sum (packet end marked by last_in).
//  - Drives the adder with {running sum, new operand} and registers the adder result as the new running sum.
//  - Presents the packet total, the element count and sticky overflow/underflow flags on a valid/ready output.
// PARAMETERS
//  EXP_WIDTH       8   exponent field width; must match the fp_adder instance
//  MANTISSA_WIDTH  23  mantissa field width; must match the fp_adder instance
//  COUNT_WIDTH     16  width of the element counter
//  (W = 1+EXP_WIDTH+MANTISSA_WIDTH; format is {sign, exp, mantissa})
// PORTS
//  clk_in         in   1    clock; all state updates on its rising edge
//  rst_n_in       in   1    reset, synchronous, active-low
//  data_in        in   W    operand
//  valid_in       in   1    data_in/last_in valid
//  last_in        in   1    data_in is the final element of the packet
//  ready_out      out  1    block can accept data_in this cycle
//  add_a_out      out  W    to fp_adder a_in (running sum)
//  add_b_out      out  W    to fp_adder b_in (operand)
//  add_sum_in     in   W    from fp_adder fpa_out
//  add_ovf_in     in   1    from fp_adder overflow_out
//  add_unf_in     in   1    from fp_adder underflow_out
//  sum_out        out  W    packet total, stable while sum_valid_out=1
//  count_out      out  CW   elements accepted in the packet
//  overflow_out   out  1    sticky: any add in the packet overflowed
//  underflow_out  out  1    sticky: any add in the packet underflowed
//  sum_valid_out  out  1    result available
//  sum_ready_in   in   1    consumer takes the result
// BEHAVIOUR
//  - Reset (rst_n_in=0 at an edge): state=IDLE; acc=0; sum_out=0; count_out=0.
//    overflow_out=0, underflow_out=0, sum_valid_out=0.
//    Applies mid-packet too: any partial sum is discarded.
//  - add_a_out=acc and add_b_out=data_in are combinational. Adder path is combinational, so one element per cycle.
//  - accept = valid_in & ready_out. ready_out=1 in IDLE and ACC, 0 in DONE.
//  - IDLE: acc=+0 (all zeros). On accept:
//    - acc<=add_sum_in; count<=1; flags<=add_ovf_in/add_unf_in.
//    - Next state: ACC, or DONE if last_in=1.
//  - ACC: on accept:
//    - acc<=add_sum_in; count<=count+1, saturating at all-ones; flags|=adder flags.
//    - Next state: DONE if last_in=1, else stay in ACC.
//  - No accept in a cycle: acc, count and flags hold.
//  - DONE: sum_out=acc; sum_valid_out=1. Outputs held stable until sum_valid_out & sum_ready_in.
//    - At that edge: state<=IDLE; acc, count and flags cleared.
//    - valid_in is ignored in DONE (no data loss; the producer stalls).
//  - Entering DONE: sum_valid_out rises the cycle after the last accept, giving 1-cycle latency.
//  - Back-to-back packets: minimum one bubble cycle (the DONE handshake) between packets.
//  - Single-element packet: sum = +0 + x = x, as produced by the adder.
//  - count_out and flags are visible live in ACC and final in DONE.
//  - Rounding, NaN and Inf handling are entirely those of fp_adder. This block does no arithmetic.
// CONFIGURATION
//  FP_ACC_SAT_EN defined:
//    - On an accept where add_ovf_in=1, acc takes {result sign, exp=all-ones-1, mantissa=all-ones}
//      (largest finite) instead of add_sum_in.
//    - overflow_out is still set.
//  FP_ACC_SAT_EN undefined: acc always takes add_sum_in unmodified.
// TESTING (EXP 8 / MANT 23, real fp_adder attached)
//  - 3-element packet:
//    - Stimulus: 0x3F800000, 0x40000000, 0x40400000 (last) on consecutive cycles.
//    - Response: sum_out=0x40C00000 (6.0), count_out=3, flags=0; sum_valid_out high the cycle after the last accept.
//  - Single element:
//    - Stimulus: 0xC0200000 (last) from IDLE.
//    - Response: sum_out=0xC0200000, count_out=1.
//  - Output backpressure:
//    - Stimulus: hold sum_ready_in=0 for 5 cycles in DONE, with valid_in=1.
//    - Response: ready_out=0, sum_out stable, no element accepted; one cycle after release, IDLE with ready_out=1.
//  - Overflow:
//    - Stimulus: 0x7F7FFFFF, 0x7F7FFFFF (last).
//    - Response: overflow_out=1; sum_out=0x7F7FFFFF with FP_ACC_SAT_EN, the adder's output without it.
//  - Reset mid-packet:
//    - Stimulus: rst_n_in=0 for 1 cycle after 2 of 4 elements, then a new packet of 0x3F800000 (last).
//    - Response: all outputs at reset values; sum_out=0x3F800000, count_out=1.
//  - Input gaps:
//    - Stimulus: valid_in toggling 1/0 across 4 elements of 1.0.
//    - Response: sum_out=0x40800000, count_out=4.

Source files
------------

// File: rtl/fp_accumulator.sv
// Streaming accumulator wrapped around a combinational fp_adder: sums one packet per result.
// Optional macro FP_ACC_SAT_EN clamps overflowed sums to the largest finite value.
module fp_accumulator #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   data_in,
  input  logic                                valid_in,
  input  logic                                last_in,
  output logic                                ready_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   add_a_out,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   add_b_out,
  input  logic [EXP_WIDTH+MANTISSA_WIDTH:0]   add_sum_in,
  input  logic                                add_ovf_in,
  input  logic                                add_unf_in,
  output logic [EXP_WIDTH+MANTISSA_WIDTH:0]   sum_out,
  output logic [COUNT_WIDTH-1:0]              count_out,
  output logic                                overflow_out,
  output logic                                underflow_out,
  output logic                                sum_valid_out,
  input  logic                                sum_ready_in
);

  localparam int W = 1 + EXP_WIDTH + MANTISSA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_r;
  logic [W-1:0]           acc_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   ovf_r;
  logic                   unf_r;
  logic                   sum_valid_r;
  logic                   ready_r;
  logic                   accept_s;
  logic [W-1:0]           next_acc_s;
  logic [COUNT_WIDTH-1:0] count_inc_s;

  // Largest finite magnitude carrying the given sign.
  function automatic logic [W-1:0] max_finite(input logic sign);
    return {sign, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANTISSA_WIDTH{1'b1}}};
  endfunction

  assign accept_s  = valid_in & ready_r;
  assign add_a_out = acc_r;
  assign add_b_out = data_in;

  assign ready_out     = ready_r;
  assign sum_out       = acc_r;
  assign count_out     = count_r;
  assign overflow_out  = ovf_r;
  assign underflow_out = unf_r;
  assign sum_valid_out = sum_valid_r;

  // Select the value the running sum takes on an accept.
  always_comb begin
    next_acc_s = add_sum_in;
`ifdef FP_ACC_SAT_EN
    if (add_ovf_in) begin
      next_acc_s = max_finite(add_sum_in[W-1]);
    end else begin
      next_acc_s = add_sum_in;
    end
`endif
  end

  // Element counter sticks at all-ones instead of wrapping.
  always_comb begin
    if (&count_r) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Packet state machine; all outputs come straight from these registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_r     <= IDLE;
      acc_r       <= {W{1'b0}};
      count_r     <= {COUNT_WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      unf_r       <= 1'b0;
      sum_valid_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        IDLE, ACC: begin
          if (accept_s) begin
            acc_r <= next_acc_s;
            if (state_r == IDLE) begin
              count_r <= {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
              ovf_r   <= add_ovf_in;
              unf_r   <= add_unf_in;
            end else begin
              count_r <= count_inc_s;
              ovf_r   <= ovf_r | add_ovf_in;
              unf_r   <= unf_r | add_unf_in;
            end
            if (last_in) begin
              state_r     <= DONE;
              sum_valid_r <= 1'b1;
              ready_r     <= 1'b0;
            end else begin
              state_r     <= ACC;
              sum_valid_r <= 1'b0;
              ready_r     <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end
        DONE: begin
          if (sum_ready_in) begin
            state_r     <= IDLE;
            acc_r       <= {W{1'b0}};
            count_r     <= {COUNT_WIDTH{1'b0}};
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
            sum_valid_r <= 1'b0;
            ready_r     <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          acc_r       <= {W{1'b0}};
          count_r     <= {COUNT_WIDTH{1'b0}};
          ovf_r       <= 1'b0;
          unf_r       <= 1'b0;
          sum_valid_r <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator; a small table-driven adder model stands in for fp_adder.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic        valid;
  logic        last;
  logic        ready;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_ovf;
  logic        add_unf;
  logic [31:0] sum;
  logic [15:0] count;
  logic        ovf;
  logic        unf;
  logic        sum_valid;
  logic        sum_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_accumulator #(.EXP_WIDTH(8), .MANTISSA_WIDTH(23), .COUNT_WIDTH(16)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .valid_in(valid), .last_in(last),
    .ready_out(ready), .add_a_out(add_a), .add_b_out(add_b), .add_sum_in(add_sum),
    .add_ovf_in(add_ovf), .add_unf_in(add_unf), .sum_out(sum), .count_out(count),
    .overflow_out(ovf), .underflow_out(unf), .sum_valid_out(sum_valid),
    .sum_ready_in(sum_ready)
  );

  // Adder results for the operand pairs the vectors use (hand-computed IEEE single values).
  always_comb begin
    add_ovf = 1'b0;
    add_unf = 1'b0;
    if (add_a == 32'h0000_0000)                               add_sum = add_b;
    else if (add_a == 32'h3F80_0000 && add_b == 32'h4000_0000) add_sum = 32'h4040_0000;
    else if (add_a == 32'h4040_0000 && add_b == 32'h4040_0000) add_sum = 32'h40C0_0000;
    else if (add_a == 32'h3F80_0000 && add_b == 32'h3F80_0000) add_sum = 32'h4000_0000;
    else if (add_a == 32'h4000_0000 && add_b == 32'h3F80_0000) add_sum = 32'h4040_0000;
    else if (add_a == 32'h4040_0000 && add_b == 32'h3F80_0000) add_sum = 32'h4080_0000;
    else if (add_a == 32'h7F7F_FFFF && add_b == 32'h7F7F_FFFF) begin
      add_sum = 32'h7F80_0000;
      add_ovf = 1'b1;
    end else if (add_a == 32'h0080_0000 && add_b == 32'h807F_FFFF) begin
      add_sum = 32'h0000_0000;
      add_unf = 1'b1;
    end else                                                   add_sum = 32'h7FC0_0000;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    data  = d;
    last  = l;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic release_result();
    sum_ready = 1'b1;
    tick();
    sum_ready = 1'b0;
    checks++;
    if (sum_valid !== 1'b0 || ready !== 1'b1 || count !== 16'd0 || sum !== 32'd0) begin
      errors++;
      $display("FAIL release: valid=%b ready=%b count=%0d sum=%h, required 0 1 0 0",
               sum_valid, ready, count, sum);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (sum !== 32'd0 || count !== 16'd0 || ovf !== 1'b0 || unf !== 1'b0 ||
        sum_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: sum=%h count=%0d ovf=%b unf=%b valid=%b ready=%b, required 0 0 0 0 0 1",
               sum, count, ovf, unf, sum_valid, ready);
    end
  endtask

  task automatic test_three_element();
    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    checks++;
    if (count !== 16'd2 || sum_valid !== 1'b0 || sum !== 32'h4040_0000) begin
      errors++;
      $display("FAIL three_live: count=%0d valid=%b sum=%h, required 2 0 40400000", count, sum_valid, sum);
    end
    send(32'h4040_0000, 1'b1);
    checks++;
    if (sum !== 32'h40C0_0000 || count !== 16'd3 || ovf !== 1'b0 || unf !== 1'b0 ||
        sum_valid !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL three_done: sum=%h count=%0d ovf=%b unf=%b valid=%b ready=%b, required 40c00000 3 0 0 1 0",
               sum, count, ovf, unf, sum_valid, ready);
    end
    release_result();
  endtask

  task automatic test_single_and_backpressure();
    logic [31:0] held;
    send(32'hC020_0000, 1'b1);
    checks++;
    if (sum !== 32'hC020_0000 || count !== 16'd1 || sum_valid !== 1'b1) begin
      errors++;
      $display("FAIL single: sum=%h count=%0d valid=%b, required c0200000 1 1", sum, count, sum_valid);
    end
    held  = 32'hC020_0000;
    data  = 32'h3F80_0000;
    valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ready !== 1'b0 || sum !== held || count !== 16'd1 || sum_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure[%0d]: ready=%b sum=%h count=%0d valid=%b, required 0 %h 1 1",
                 i, ready, sum, count, sum_valid, held);
      end
    end
    valid = 1'b0;
    release_result();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_sum;
`ifdef FP_ACC_SAT_EN
    exp_sum = 32'h7F7F_FFFF;
`else
    exp_sum = 32'h7F80_0000;
`endif
    send(32'h7F7F_FFFF, 1'b0);
    send(32'h7F7F_FFFF, 1'b1);
    checks++;
    if (ovf !== 1'b1 || unf !== 1'b0 || sum !== exp_sum || count !== 16'd2) begin
      errors++;
      $display("FAIL overflow: ovf=%b unf=%b sum=%h count=%0d, required 1 0 %h 2", ovf, unf, sum, count, exp_sum);
    end
    release_result();
  endtask

  task automatic test_underflow_sticky();
    send(32'h0080_0000, 1'b0);
    send(32'h807F_FFFF, 1'b0);
    send(32'h3F80_0000, 1'b1);
    checks++;
    if (unf !== 1'b1 || ovf !== 1'b0 || sum !== 32'h3F80_0000 || count !== 16'd3) begin
      errors++;
      $display("FAIL underflow: unf=%b ovf=%b sum=%h count=%0d, required 1 0 3f800000 3", unf, ovf, sum, count);
    end
    release_result();
  endtask

  task automatic test_reset_mid_packet();
    send(32'h3F80_0000, 1'b0);
    send(32'h3F80_0000, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (sum !== 32'd0 || count !== 16'd0 || ovf !== 1'b0 || unf !== 1'b0 ||
        sum_valid !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: sum=%h count=%0d ovf=%b unf=%b valid=%b ready=%b, required 0 0 0 0 0 1",
               sum, count, ovf, unf, sum_valid, ready);
    end
    send(32'h3F80_0000, 1'b1);
    checks++;
    if (sum !== 32'h3F80_0000 || count !== 16'd1 || sum_valid !== 1'b1) begin
      errors++;
      $display("FAIL after_reset: sum=%h count=%0d valid=%b, required 3f800000 1 1", sum, count, sum_valid);
    end
    release_result();
  endtask

  task automatic test_input_gaps();
    for (int i = 0; i < 4; i++) begin
      send(32'h3F80_0000, (i == 3) ? 1'b1 : 1'b0);
      if (i < 3) begin
        tick();
        checks++;
        if (count !== 16'(i + 1) || sum_valid !== 1'b0) begin
          errors++;
          $display("FAIL gap_hold[%0d]: count=%0d valid=%b, required %0d 0", i, count, sum_valid, i + 1);
        end
      end
    end
    checks++;
    if (sum !== 32'h4080_0000 || count !== 16'd4 || sum_valid !== 1'b1) begin
      errors++;
      $display("FAIL gaps: sum=%h count=%0d valid=%b, required 40800000 4 1", sum, count, sum_valid);
    end
    release_result();
  endtask

  task automatic test_count_saturation();
    data  = 32'h0000_0000;
    last  = 1'b0;
    valid = 1'b1;
    for (int i = 0; i < 65535; i++) tick();
    checks++;
    if (count !== 16'hFFFF || sum_valid !== 1'b0) begin
      errors++;
      $display("FAIL count_max: count=%h valid=%b, required ffff 0", count, sum_valid);
    end
    tick();
    last = 1'b1;
    tick();
    valid = 1'b0;
    last  = 1'b0;
    checks++;
    if (count !== 16'hFFFF || sum !== 32'd0 || sum_valid !== 1'b1) begin
      errors++;
      $display("FAIL count_sat: count=%h sum=%h valid=%b, required ffff 0 1", count, sum, sum_valid);
    end
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    data      = 32'd0;
    valid     = 1'b0;
    last      = 1'b0;
    sum_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_three_element();
    test_single_and_backpressure();
    test_overflow();
    test_underflow_sticky();
    test_reset_mid_packet();
    test_input_gaps();
    test_count_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
